// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings, FSM state types and the read-beat record used by the
// RAM-backed AXI4 target.
package axi4_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] SIZE_8B     = 3'd3;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_DATA,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_BURST
  } rd_state_t;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_beat_t;

endpackage

// File: rtl/axi4_target_ram_if.sv
// AXI4 write (AW/W/B) and read (AR/R) channel bundle; IDs are not carried.
interface axi4_target_ram_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64
);

  logic [ADDR_WIDTH-1:0]   axi4target_aw_addr;
  logic                    axi4target_aw_valid;
  logic                    axi4target_aw_ready;
  logic [1:0]              axi4target_aw_burst;
  logic [2:0]              axi4target_aw_size;
  logic [7:0]              axi4target_aw_len;
  logic [DATA_WIDTH-1:0]   axi4target_w_data;
  logic [DATA_WIDTH/8-1:0] axi4target_w_strb;
  logic                    axi4target_w_valid;
  logic                    axi4target_w_ready;
  logic                    axi4target_w_last;
  logic [1:0]              axi4target_b_resp;
  logic                    axi4target_b_resp_valid;
  logic                    axi4target_b_resp_ready;
  logic [ADDR_WIDTH-1:0]   axi4target_ar_addr;
  logic                    axi4target_ar_valid;
  logic                    axi4target_ar_ready;
  logic [1:0]              axi4target_ar_burst;
  logic [2:0]              axi4target_ar_size;
  logic [7:0]              axi4target_ar_len;
  logic [DATA_WIDTH-1:0]   axi4target_r_data;
  logic                    axi4target_r_valid;
  logic                    axi4target_r_ready;
  logic [1:0]              axi4target_r_resp;
  logic                    axi4target_r_last;

  modport slave (
    input  axi4target_aw_addr, axi4target_aw_valid, axi4target_aw_burst,
           axi4target_aw_size, axi4target_aw_len,
    output axi4target_aw_ready,
    input  axi4target_w_data, axi4target_w_strb, axi4target_w_valid, axi4target_w_last,
    output axi4target_w_ready,
    output axi4target_b_resp, axi4target_b_resp_valid,
    input  axi4target_b_resp_ready,
    input  axi4target_ar_addr, axi4target_ar_valid, axi4target_ar_burst,
           axi4target_ar_size, axi4target_ar_len,
    output axi4target_ar_ready,
    output axi4target_r_data, axi4target_r_valid, axi4target_r_resp, axi4target_r_last,
    input  axi4target_r_ready
  );

  modport master (
    output axi4target_aw_addr, axi4target_aw_valid, axi4target_aw_burst,
           axi4target_aw_size, axi4target_aw_len,
    input  axi4target_aw_ready,
    output axi4target_w_data, axi4target_w_strb, axi4target_w_valid, axi4target_w_last,
    input  axi4target_w_ready,
    input  axi4target_b_resp, axi4target_b_resp_valid,
    output axi4target_b_resp_ready,
    output axi4target_ar_addr, axi4target_ar_valid, axi4target_ar_burst,
           axi4target_ar_size, axi4target_ar_len,
    input  axi4target_ar_ready,
    input  axi4target_r_data, axi4target_r_valid, axi4target_r_resp, axi4target_r_last,
    output axi4target_r_ready
  );

endinterface

// File: rtl/axi4_target_ram_dpram.sv
// Simple dual-port RAM: byte-enabled write port, registered read port,
// read-first on a same-word collision.
module axi4_target_dpram #(
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [$clog2(DEPTH)-1:0]  waddr,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic                      re,
  input  logic [$clog2(DEPTH)-1:0]  raddr,
  output logic [DATA_WIDTH-1:0]     rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Non-blocking update of mem makes a colliding read see the old word.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi4_target_ram.sv
// AXI4 INCR-burst target backed by an internal dual-port RAM; one outstanding
// transaction per direction, SLVERR for bad burst/size or out-of-range beats.
module axi4_target_ram
  import axi4_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           AXI_DATA_WIDTH = 64,
  parameter int unsigned           AXI_ID_WIDTH   = 1,
  parameter int unsigned           MEM_DEPTH      = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
  input logic              clk,
  input logic              reset,
  axi4_target_ram_if.slave bus
);

  localparam int unsigned     IDX_W   = $clog2(MEM_DEPTH);
  localparam int unsigned     WW      = ADDR_WIDTH - 2;
  localparam logic [WW-1:0]   DEPTH_W = WW'(MEM_DEPTH);

  if (AXI_DATA_WIDTH != 64 || AXI_ID_WIDTH < 1 ||
      (MEM_DEPTH & (MEM_DEPTH - 1)) != 0 || BASE_ADDR[2:0] != 3'd0) begin : g_cfg_check
    $error("axi4_target_ram: unsupported parameter set");
  end

  // Word index carries one spare bit so start+len never wraps back into range.
  function automatic logic [WW-1:0] word_of(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return WW'(off >> 3);
  endfunction

  function automatic logic proto_bad(input logic [1:0] burst, input logic [2:0] size);
    return (burst != BURST_INCR) || (size != SIZE_8B);
  endfunction

  // ---------------- write channel ----------------
  wr_state_t     wr_state, wr_next;
  logic [WW-1:0] wr_word;
  logic [8:0]    wr_left;
  logic          wr_proto_err, wr_err;
  logic          aw_hs, w_hs, wr_final, ram_we;
  logic [AXI_DATA_WIDTH-1:0] ram_rdata;

  assign aw_hs    = (wr_state == WR_IDLE) && bus.axi4target_aw_valid;
  assign w_hs     = (wr_state == WR_DATA) && bus.axi4target_w_valid;
  assign wr_final = (wr_left == 9'd1);
  assign ram_we   = w_hs && !wr_proto_err && (wr_word < DEPTH_W);

  always_ff @(posedge clk) begin
    if (reset) wr_state <= WR_IDLE;
    else       wr_state <= wr_next;
  end

  always_comb begin
    wr_next                     = wr_state;
    bus.axi4target_aw_ready     = 1'b0;
    bus.axi4target_w_ready      = 1'b0;
    bus.axi4target_b_resp_valid = 1'b0;
    bus.axi4target_b_resp       = RESP_OKAY;
    unique case (wr_state)
      WR_IDLE: begin
        bus.axi4target_aw_ready = 1'b1;
        if (bus.axi4target_aw_valid) wr_next = WR_DATA;
      end
      WR_DATA: begin
        bus.axi4target_w_ready = 1'b1;
        if (bus.axi4target_w_valid && wr_final) wr_next = WR_RESP;
      end
      WR_RESP: begin
        bus.axi4target_b_resp_valid = 1'b1;
        bus.axi4target_b_resp       = wr_err ? RESP_SLVERR : RESP_OKAY;
        if (bus.axi4target_b_resp_ready) wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_word      <= '0;
      wr_left      <= '0;
      wr_proto_err <= 1'b0;
      wr_err       <= 1'b0;
    end else if (aw_hs) begin
      wr_word      <= word_of(bus.axi4target_aw_addr);
      wr_left      <= {1'b0, bus.axi4target_aw_len} + 9'd1;
      wr_proto_err <= proto_bad(bus.axi4target_aw_burst, bus.axi4target_aw_size);
      wr_err       <= proto_bad(bus.axi4target_aw_burst, bus.axi4target_aw_size) ||
                      ((word_of(bus.axi4target_aw_addr) + WW'(bus.axi4target_aw_len)) >= DEPTH_W);
    end else if (w_hs) begin
      wr_word <= wr_word + 1'b1;
      wr_left <= wr_left - 9'd1;
      if (bus.axi4target_w_last != wr_final) wr_err <= 1'b1;
    end
  end

  // ---------------- read channel ----------------
  rd_state_t     rd_state, rd_next;
  logic [WW-1:0] rd_word;
  logic [8:0]    rd_left;
  logic          rd_proto_err;
  logic          inflight, inflight_err, inflight_last;
  r_beat_t       q0, q1, push_beat;
  logic [1:0]    q_cnt;
  logic [2:0]    occ;
  logic          pop, issue;

  always_ff @(posedge clk) begin
    if (reset) rd_state <= RD_IDLE;
    else       rd_state <= rd_next;
  end

  // A RAM read is only issued when the skid buffer is guaranteed a free slot.
  always_comb begin
    rd_next                 = rd_state;
    bus.axi4target_ar_ready = 1'b0;
    issue                   = 1'b0;
    occ                     = {1'b0, q_cnt} + {2'b00, inflight};
    pop                     = (q_cnt != 2'd0) && bus.axi4target_r_ready;
    push_beat.data          = inflight_err ? 64'd0 : ram_rdata;
    push_beat.resp          = inflight_err ? RESP_SLVERR : RESP_OKAY;
    push_beat.last          = inflight_last;
    unique case (rd_state)
      RD_IDLE: begin
        bus.axi4target_ar_ready = 1'b1;
        if (bus.axi4target_ar_valid) rd_next = RD_BURST;
      end
      RD_BURST: begin
        issue = (rd_left != 9'd0) && ((occ - {2'b00, pop}) < 3'd2);
        if (pop && q0.last) rd_next = RD_IDLE;
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_word       <= '0;
      rd_left       <= '0;
      rd_proto_err  <= 1'b0;
      inflight      <= 1'b0;
      inflight_err  <= 1'b0;
      inflight_last <= 1'b0;
      q0            <= '0;
      q1            <= '0;
      q_cnt         <= '0;
    end else begin
      if (rd_state == RD_IDLE && bus.axi4target_ar_valid) begin
        rd_word      <= word_of(bus.axi4target_ar_addr);
        rd_left      <= {1'b0, bus.axi4target_ar_len} + 9'd1;
        rd_proto_err <= proto_bad(bus.axi4target_ar_burst, bus.axi4target_ar_size);
      end else if (issue) begin
        rd_word <= rd_word + 1'b1;
        rd_left <= rd_left - 9'd1;
      end
      inflight      <= issue;
      inflight_err  <= rd_proto_err || (rd_word >= DEPTH_W);
      inflight_last <= (rd_left == 9'd1);

      unique case ({inflight, pop})
        2'b10: begin
          if (q_cnt == 2'd0) q0 <= push_beat;
          else               q1 <= push_beat;
          q_cnt <= q_cnt + 2'd1;
        end
        2'b01: begin
          q0    <= q1;
          q_cnt <= q_cnt - 2'd1;
        end
        2'b11: begin
          if (q_cnt == 2'd1) q0 <= push_beat;
          else begin
            q0 <= q1;
            q1 <= push_beat;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.axi4target_r_valid = (q_cnt != 2'd0);
  assign bus.axi4target_r_data  = q0.data;
  assign bus.axi4target_r_resp  = q0.resp;
  assign bus.axi4target_r_last  = q0.last && (q_cnt != 2'd0);

  axi4_target_dpram #(
    .DEPTH      (MEM_DEPTH),
    .DATA_WIDTH (AXI_DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_word[IDX_W-1:0]),
    .wstrb (bus.axi4target_w_strb),
    .wdata (bus.axi4target_w_data),
    .re    (issue),
    .raddr (rd_word[IDX_W-1:0]),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_axi4_target_ram.sv
// Bench for axi4_target_ram: directed and randomized bursts against a sparse
// word-level memory model.
module tb_axi4_target_ram;

  localparam int unsigned DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axi4_target_ram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) bus ();

  axi4_target_ram #(
    .ADDR_WIDTH     (32),
    .AXI_DATA_WIDTH (64),
    .AXI_ID_WIDTH   (1),
    .MEM_DEPTH      (DEPTH),
    .BASE_ADDR      (BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] model [longint unsigned];
  logic [63:0] wdat [256];
  logic [7:0]  wstb [256];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint unsigned first_word(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return {32'h0, off} >> 3;
  endfunction

  // w_last is driven only on beat last_at; a normal burst passes last_at == len.
  task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [2:0] size, input int last_at, input string tag);
    longint unsigned w0, w;
    bit proto, err;
    int n;
    proto = (burst != 2'b01) || (size != 3'd3);
    w0 = first_word(addr);
    err = proto || (last_at != len);
    for (int i = 0; i <= len; i++) if (w0 + longint'(i) >= DEPTH) err = 1'b1;

    bus.axi4target_aw_addr  = addr;
    bus.axi4target_aw_len   = 8'(len);
    bus.axi4target_aw_burst = burst;
    bus.axi4target_aw_size  = size;
    bus.axi4target_aw_valid = 1'b1;
    n = 0;
    while (!bus.axi4target_aw_ready && n < 200) begin tick(); n++; end
    if (n >= 200) begin checks++; errors++; $display("FAIL %s aw timeout", tag); end
    tick();
    bus.axi4target_aw_valid = 1'b0;

    for (int i = 0; i <= len; i++) begin
      bus.axi4target_w_data  = wdat[i];
      bus.axi4target_w_strb  = wstb[i];
      bus.axi4target_w_last  = (i == last_at);
      bus.axi4target_w_valid = 1'b1;
      n = 0;
      while (!bus.axi4target_w_ready && n < 200) begin tick(); n++; end
      if (n >= 200) begin checks++; errors++; $display("FAIL %s w beat %0d timeout", tag, i); end
      tick();
      w = w0 + longint'(i);
      if (!proto && w < DEPTH) begin
        logic [63:0] cur;
        cur = model.exists(w) ? model[w] : 64'd0;
        for (int b = 0; b < 8; b++) if (wstb[i][b]) cur[b*8 +: 8] = wdat[i][b*8 +: 8];
        model[w] = cur;
      end
    end
    bus.axi4target_w_valid = 1'b0;
    bus.axi4target_w_last  = 1'b0;

    repeat ($urandom_range(0, 2)) tick();
    bus.axi4target_b_resp_ready = 1'b1;
    n = 0;
    while (!bus.axi4target_b_resp_valid && n < 200) begin tick(); n++; end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL %s b timeout", tag); end
    else if (bus.axi4target_b_resp !== (err ? 2'b10 : 2'b00)) begin
      errors++;
      $display("FAIL %s b_resp got %b expected %b", tag, bus.axi4target_b_resp, err ? 2'b10 : 2'b00);
    end
    tick();
    bus.axi4target_b_resp_ready = 1'b0;
  endtask

  // mode 0: r_ready always 1; mode 1: 1,0,0,1 repeating; mode 2: random.
  task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                         input logic [2:0] size, input int mode, input bit check_lat,
                         input string tag);
    logic [63:0] ed [256];
    logic [1:0]  er [256];
    longint unsigned w0, w;
    bit proto, held;
    int n, beat, cyc, first;
    logic [63:0] hd;
    logic [1:0]  hr;
    logic        hl;
    proto = (burst != 2'b01) || (size != 3'd3);
    w0 = first_word(addr);
    for (int i = 0; i <= len; i++) begin
      w = w0 + longint'(i);
      if (proto || w >= DEPTH) begin ed[i] = 64'd0; er[i] = 2'b10; end
      else begin ed[i] = model.exists(w) ? model[w] : 64'd0; er[i] = 2'b00; end
    end

    bus.axi4target_ar_addr  = addr;
    bus.axi4target_ar_len   = 8'(len);
    bus.axi4target_ar_burst = burst;
    bus.axi4target_ar_size  = size;
    bus.axi4target_ar_valid = 1'b1;
    n = 0;
    while (!bus.axi4target_ar_ready && n < 200) begin tick(); n++; end
    if (n >= 200) begin checks++; errors++; $display("FAIL %s ar timeout", tag); end
    tick();
    bus.axi4target_ar_valid = 1'b0;

    beat = 0; cyc = 0; first = -1; held = 1'b0;
    hd = '0; hr = '0; hl = 1'b0;
    while (beat <= len && cyc < 600) begin
      case (mode)
        0:       bus.axi4target_r_ready = 1'b1;
        1:       bus.axi4target_r_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: bus.axi4target_r_ready = 1'($urandom_range(0, 1));
      endcase
      if (held) begin
        checks++;
        if ({bus.axi4target_r_valid, bus.axi4target_r_data, bus.axi4target_r_resp, bus.axi4target_r_last}
            !== {1'b1, hd, hr, hl}) begin
          errors++;
          $display("FAIL %s stall beat %0d: got v=%b d=%h r=%b l=%b expected v=1 d=%h r=%b l=%b",
                   tag, beat, bus.axi4target_r_valid, bus.axi4target_r_data,
                   bus.axi4target_r_resp, bus.axi4target_r_last, hd, hr, hl);
        end
      end
      if (bus.axi4target_r_valid) begin
        if (first < 0) first = cyc;
        if (bus.axi4target_r_ready) begin
          checks++;
          if ({bus.axi4target_r_data, bus.axi4target_r_resp, bus.axi4target_r_last}
              !== {ed[beat], er[beat], beat == len}) begin
            errors++;
            $display("FAIL %s beat %0d: got d=%h r=%b l=%b expected d=%h r=%b l=%b",
                     tag, beat, bus.axi4target_r_data, bus.axi4target_r_resp,
                     bus.axi4target_r_last, ed[beat], er[beat], beat == len);
          end
          beat++;
        end
      end
      held = bus.axi4target_r_valid && !bus.axi4target_r_ready;
      hd = bus.axi4target_r_data; hr = bus.axi4target_r_resp; hl = bus.axi4target_r_last;
      tick();
      cyc++;
    end
    bus.axi4target_r_ready = 1'b0;
    if (beat <= len) begin
      checks++; errors++;
      $display("FAIL %s r timeout after %0d of %0d beats", tag, beat, len + 1);
    end
    if (check_lat) begin
      checks++;
      if (first !== 2) begin errors++; $display("FAIL %s first r_valid latency got %0d expected 2", tag, first); end
    end
    checks++;
    if ({bus.axi4target_r_valid, bus.axi4target_ar_ready} !== 2'b01) begin
      errors++;
      $display("FAIL %s post-burst r_valid/ar_ready got %b%b expected 01", tag,
               bus.axi4target_r_valid, bus.axi4target_ar_ready);
    end
  endtask

  task automatic fill(input int len, input bit full_strb);
    for (int i = 0; i <= len; i++) begin
      wdat[i] = {$urandom, $urandom};
      wstb[i] = full_strb ? 8'hFF : 8'($urandom);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    checks++; if (bus.axi4target_aw_ready !== 1'b1) begin errors++; $display("FAIL reset aw_ready got %b expected 1", bus.axi4target_aw_ready); end
    checks++; if (bus.axi4target_ar_ready !== 1'b1) begin errors++; $display("FAIL reset ar_ready got %b expected 1", bus.axi4target_ar_ready); end
    checks++; if (bus.axi4target_w_ready !== 1'b0) begin errors++; $display("FAIL reset w_ready got %b expected 0", bus.axi4target_w_ready); end
    checks++; if (bus.axi4target_b_resp_valid !== 1'b0) begin errors++; $display("FAIL reset b_valid got %b expected 0", bus.axi4target_b_resp_valid); end
    checks++; if (bus.axi4target_r_valid !== 1'b0) begin errors++; $display("FAIL reset r_valid got %b expected 0", bus.axi4target_r_valid); end
    checks++; if (bus.axi4target_r_last !== 1'b0) begin errors++; $display("FAIL reset r_last got %b expected 0", bus.axi4target_r_last); end
    checks++; if (bus.axi4target_b_resp !== 2'b00) begin errors++; $display("FAIL reset b_resp got %b expected 00", bus.axi4target_b_resp); end
    checks++; if (bus.axi4target_r_resp !== 2'b00) begin errors++; $display("FAIL reset r_resp got %b expected 00", bus.axi4target_r_resp); end
    checks++; if (bus.axi4target_r_data !== 64'd0) begin errors++; $display("FAIL reset r_data got %h expected 0", bus.axi4target_r_data); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    for (int i = 0; i < 4; i++) begin wdat[i] = 64'(8'h11 * (i + 1)); wstb[i] = 8'hFF; end
    do_write(32'h100, 3, 2'b01, 3'd3, 3, "wr_basic");
    do_read(32'h100, 3, 2'b01, 3'd3, 0, 1'b1, "rd_basic");
  endtask

  task automatic test_partial_strobe();
    wdat[0] = 64'd0; wstb[0] = 8'hFF;
    do_write(32'h200, 0, 2'b01, 3'd3, 0, "strb_clear");
    wdat[0] = 64'hAABBCCDD_EEFF0011; wstb[0] = 8'h0F;
    do_write(32'h200, 0, 2'b01, 3'd3, 0, "strb_partial");
    checks++;
    if (model[first_word(32'h200)] !== 64'h00000000_EEFF0011) begin
      errors++;
      $display("FAIL strb_model got %h expected 00000000eeff0011", model[first_word(32'h200)]);
    end
    do_read(32'h200, 0, 2'b01, 3'd3, 0, 1'b0, "strb_read");
  endtask

  task automatic test_backpressure();
    fill(7, 1'b1);
    do_write(32'h400, 7, 2'b01, 3'd3, 7, "bp_write");
    do_read(32'h400, 7, 2'b01, 3'd3, 1, 1'b0, "bp_toggle");
    do_read(32'h400, 7, 2'b01, 3'd3, 2, 1'b0, "bp_random");
  endtask

  task automatic test_out_of_range();
    fill(1, 1'b1);
    do_write(BASE + DEPTH * 8 - 8, 1, 2'b01, 3'd3, 1, "oor_write");
    do_read(BASE + DEPTH * 8 - 8, 1, 2'b01, 3'd3, 0, 1'b0, "oor_read");
    do_read(BASE + DEPTH * 8, 0, 2'b01, 3'd3, 0, 1'b0, "oor_noalias");
    do_read(32'hFFFF_FFF8, 0, 2'b01, 3'd3, 0, 1'b0, "oor_below");
  endtask

  task automatic test_protocol_errors();
    wdat[0] = 64'hDEAD_BEEF_0BAD_F00D; wstb[0] = 8'hFF;
    do_write(32'h100, 0, 2'b00, 3'd3, 0, "perr_burst");
    do_write(32'h108, 0, 2'b01, 3'd2, 0, "perr_size");
    do_read(32'h100, 3, 2'b01, 3'd3, 0, 1'b0, "perr_unchanged");
    fill(3, 1'b1);
    do_write(32'h300, 3, 2'b01, 3'd3, 1, "perr_early_last");
    do_read(32'h300, 3, 2'b01, 3'd3, 0, 1'b0, "perr_early_read");
    fill(1, 1'b1);
    do_write(32'h340, 1, 2'b01, 3'd3, -1, "perr_no_last");
    do_read(32'h300, 3, 2'b00, 3'd3, 0, 1'b0, "perr_rd_burst");
    do_read(32'h300, 1, 2'b01, 3'd1, 2, 1'b0, "perr_rd_size");
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      fill(15, 1'b1);
      do_write(32'h1000 + 32'(k * 128), 15, 2'b01, 3'd3, 15, "rnd_init");
    end
    for (int k = 0; k < 16; k++) begin
      int len, w;
      len = int'($urandom_range(0, 7));
      w   = int'($urandom_range(0, 63 - len));
      if ($urandom_range(0, 1) == 1) begin
        fill(len, 1'b0);
        do_write(32'h1000 + 32'(w * 8), len, 2'b01, 3'd3, len, "rnd_write");
      end else begin
        do_read(32'h1000 + 32'(w * 8), len, 2'b01, 3'd3, 2, 1'b0, "rnd_read");
      end
    end
  endtask

  task automatic test_back_to_back();
    fill(7, 1'b1);
    fork
      do_write(32'h2000, 7, 2'b01, 3'd3, 7, "b2b_write");
      do_read(32'h400, 7, 2'b01, 3'd3, 0, 1'b1, "b2b_read_par");
    join
    do_read(32'h2000, 7, 2'b01, 3'd3, 0, 1'b1, "b2b_read_a");
    do_read(32'h2008, 3, 2'b01, 3'd3, 0, 1'b1, "b2b_read_b");
  endtask

  task automatic test_reset_mid_burst();
    int beat, n;
    longint unsigned w0;
    fill(7, 1'b1);
    do_write(32'h600, 7, 2'b01, 3'd3, 7, "rst_prep");
    w0 = first_word(32'h600);

    bus.axi4target_ar_addr = 32'h600; bus.axi4target_ar_len = 8'd7;
    bus.axi4target_ar_burst = 2'b01; bus.axi4target_ar_size = 3'd3;
    bus.axi4target_ar_valid = 1'b1;
    n = 0;
    while (!bus.axi4target_ar_ready && n < 200) begin tick(); n++; end
    tick();
    bus.axi4target_ar_valid = 1'b0;
    bus.axi4target_r_ready = 1'b1;
    beat = 0; n = 0;
    while (beat < 2 && n < 50) begin
      if (bus.axi4target_r_valid) begin
        checks++;
        if (bus.axi4target_r_data !== model[w0 + longint'(beat)]) begin
          errors++;
          $display("FAIL rst_pre beat %0d got %h expected %h", beat, bus.axi4target_r_data, model[w0 + longint'(beat)]);
        end
        beat++;
      end
      tick(); n++;
    end
    bus.axi4target_r_ready = 1'b0;
    n = 0;
    while (!bus.axi4target_r_valid && n < 20) begin tick(); n++; end
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.axi4target_r_valid, bus.axi4target_ar_ready, bus.axi4target_r_last} !== 3'b010) begin
      errors++;
      $display("FAIL rst_read r_valid/ar_ready/r_last got %b%b%b expected 010",
               bus.axi4target_r_valid, bus.axi4target_ar_ready, bus.axi4target_r_last);
    end
    reset = 1'b0;
    tick();

    fill(3, 1'b1);
    bus.axi4target_aw_addr = 32'h700; bus.axi4target_aw_len = 8'd3;
    bus.axi4target_aw_burst = 2'b01; bus.axi4target_aw_size = 3'd3;
    bus.axi4target_aw_valid = 1'b1;
    tick();
    bus.axi4target_aw_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.axi4target_w_data = wdat[i]; bus.axi4target_w_strb = 8'hFF;
      bus.axi4target_w_last = 1'b0; bus.axi4target_w_valid = 1'b1;
      n = 0;
      while (!bus.axi4target_w_ready && n < 20) begin tick(); n++; end
      tick();
      model[first_word(32'h700) + longint'(i)] = wdat[i];
    end
    bus.axi4target_w_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({bus.axi4target_aw_ready, bus.axi4target_w_ready, bus.axi4target_b_resp_valid} !== 3'b100) begin
      errors++;
      $display("FAIL rst_write aw_ready/w_ready/b_valid got %b%b%b expected 100",
               bus.axi4target_aw_ready, bus.axi4target_w_ready, bus.axi4target_b_resp_valid);
    end
    do_read(32'h600, 7, 2'b01, 3'd3, 0, 1'b1, "rst_after_read");
    do_read(32'h700, 1, 2'b01, 3'd3, 0, 1'b0, "rst_after_write");
  endtask

  initial begin
    reset = 1'b1;
    bus.axi4target_aw_addr = '0; bus.axi4target_aw_valid = 1'b0; bus.axi4target_aw_burst = 2'b01;
    bus.axi4target_aw_size = 3'd3; bus.axi4target_aw_len = '0;
    bus.axi4target_w_data = '0; bus.axi4target_w_strb = '0; bus.axi4target_w_valid = 1'b0;
    bus.axi4target_w_last = 1'b0; bus.axi4target_b_resp_ready = 1'b0;
    bus.axi4target_ar_addr = '0; bus.axi4target_ar_valid = 1'b0; bus.axi4target_ar_burst = 2'b01;
    bus.axi4target_ar_size = 3'd3; bus.axi4target_ar_len = '0; bus.axi4target_r_ready = 1'b0;

    test_reset();
    test_write_read();
    test_partial_strobe();
    test_backpressure();
    test_out_of_range();
    test_protocol_errors();
    test_random();
    test_back_to_back();
    test_reset_mid_burst();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
